// File: rtl/circle_plot.sv
// Midpoint circle rasteriser: walks one octant and emits either the eight mirrored
// outline points or four horizontal spans per step to a valid/ready pixel sink.
module circle_plot #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int XW       = 8,
   parameter int YW       = 7,
   parameter int RW       = 8,
   parameter int CW       = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          done,
   input  logic [XW-1:0] centre_x,
   input  logic [YW-1:0] centre_y,
   input  logic [RW-1:0] radius,
   input  logic [CW-1:0] colour,
   input  logic          fill,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [CW-1:0] vga_colour,
   output logic          vga_plot,
   input  logic          vga_ready,
   output logic [2:0]    state_dbg
);
   localparam int MW  = (XW > YW) ? ((XW > RW) ? XW : RW) : ((YW > RW) ? YW : RW);
   localparam int AW  = MW + 2;
   localparam int CRW = RW + 2;

   typedef logic signed [AW-1:0]  coord_t;
   typedef logic signed [CRW-1:0] crit_t;
   typedef enum logic [2:0] {IDLE, SETUP, OUTLINE, SPAN, STEP, DONE} state_t;

   localparam coord_t SW_S = coord_t'(SCREEN_W);
   localparam coord_t SH_S = coord_t'(SCREEN_H);

   // Sink handshake: a pixel moves on every rising edge where vga_plot and vga_ready are both
   // high; while vga_plot is high and vga_ready low, vga_x/vga_y/vga_colour are held unchanged.
   state_t        state_q, state_d;
   logic [XW-1:0] cx_q, cx_d;
   logic [YW-1:0] cy_q, cy_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] col_q, col_d;
   logic          fill_q, fill_d;
   coord_t        ox_q, ox_d, oy_q, oy_d, xpos_q, xpos_d;
   crit_t         crit_q, crit_d;
   logic [2:0]    idx_q, idx_d;
   logic          vga_plot_q, vga_plot_d, done_q, done_d;
   logic [XW-1:0] vga_x_q, vga_x_d;
   logic [YW-1:0] vga_y_q, vga_y_d;
   logic [CW-1:0] vga_col_q, vga_col_d;

   coord_t cx_s, cy_s, step_inc, cand_x, cand_y;
   logic   adv, on_screen;

   assign cx_s = coord_t'(cx_q);
   assign cy_s = coord_t'(cy_q);

   // Spans 0/1 are rows cy+-oy spanning +-ox; spans 2/3 are rows cy+-ox spanning +-oy.
   function automatic coord_t span_left(input logic [2:0] k, input coord_t cx, input coord_t ox,
                                        input coord_t oy);
      return (k < 3'd2) ? cx - ox : cx - oy;
   endfunction

   function automatic coord_t span_right(input logic [2:0] k, input coord_t cx, input coord_t ox,
                                         input coord_t oy);
      return (k < 3'd2) ? cx + ox : cx + oy;
   endfunction

   function automatic coord_t span_row(input logic [2:0] k, input coord_t cy, input coord_t ox,
                                       input coord_t oy);
      case (k)
         3'd0:    return cy + oy;
         3'd1:    return cy - oy;
         3'd2:    return cy + ox;
         default: return cy - ox;
      endcase
   endfunction

   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      r_d      = r_q;
      col_d    = col_q;
      fill_d   = fill_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      crit_d   = crit_q;
      idx_d    = idx_q;
      xpos_d   = xpos_q;
      step_inc = '0;
      adv      = !vga_plot_q || vga_ready;
      case (state_q)
         IDLE: if (start) begin
            cx_d    = centre_x;
            cy_d    = centre_y;
            r_d     = radius;
            col_d   = colour;
            fill_d  = fill;
            state_d = SETUP;
         end
         SETUP: begin
            ox_d    = coord_t'(r_q);
            oy_d    = '0;
            crit_d  = crit_t'(1) - crit_t'(r_q);
            idx_d   = '0;
            xpos_d  = cx_s - coord_t'(r_q);
            state_d = fill_q ? SPAN : OUTLINE;
         end
         OUTLINE: if (adv) begin
            if (idx_q == 3'd7) state_d = STEP;
            else               idx_d   = idx_q + 3'd1;
         end
         SPAN: if (adv) begin
            if (xpos_q != span_right(idx_q, cx_s, ox_q, oy_q)) begin
               xpos_d = xpos_q + coord_t'(1);
            end else if (idx_q == 3'd3) begin
               state_d = STEP;
            end else begin
               idx_d  = idx_q + 3'd1;
               xpos_d = span_left(idx_q + 3'd1, cx_s, ox_q, oy_q);
            end
         end
         STEP: begin
            oy_d = oy_q + coord_t'(1);
            if (crit_q[CRW-1] || (crit_q == '0)) begin
               step_inc = (oy_d <<< 1) + coord_t'(1);
            end else begin
               ox_d     = ox_q - coord_t'(1);
               step_inc = ((oy_d - ox_d) <<< 1) + coord_t'(1);
            end
            crit_d  = crit_q + crit_t'(step_inc);
            idx_d   = '0;
            xpos_d  = cx_s - ox_d;
            state_d = (oy_d > ox_d) ? DONE : (fill_q ? SPAN : OUTLINE);
         end
         DONE: if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!start && (state_q inside {SETUP, OUTLINE, SPAN, STEP})) state_d = IDLE;
   end

   // Outputs are registered, so the candidate is derived from the next cursor position.
   always_comb begin
      cand_x = '0;
      cand_y = '0;
      if (state_d == SPAN) begin
         cand_x = xpos_d;
         cand_y = span_row(idx_d, cy_s, ox_d, oy_d);
      end else begin
         case (idx_d)
            3'd0:    begin cand_x = cx_s + ox_d; cand_y = cy_s + oy_d; end
            3'd1:    begin cand_x = cx_s + oy_d; cand_y = cy_s + ox_d; end
            3'd2:    begin cand_x = cx_s - oy_d; cand_y = cy_s + ox_d; end
            3'd3:    begin cand_x = cx_s - ox_d; cand_y = cy_s + oy_d; end
            3'd4:    begin cand_x = cx_s - ox_d; cand_y = cy_s - oy_d; end
            3'd5:    begin cand_x = cx_s - oy_d; cand_y = cy_s - ox_d; end
            3'd6:    begin cand_x = cx_s + oy_d; cand_y = cy_s - ox_d; end
            default: begin cand_x = cx_s + ox_d; cand_y = cy_s - oy_d; end
         endcase
      end
      on_screen  = !cand_x[AW-1] && (cand_x < SW_S) && !cand_y[AW-1] && (cand_y < SH_S);
      vga_plot_d = ((state_d == OUTLINE) || (state_d == SPAN)) && on_screen;
      vga_x_d    = vga_plot_d ? cand_x[XW-1:0] : '0;
      vga_y_d    = vga_plot_d ? cand_y[YW-1:0] : '0;
      vga_col_d  = (state_d inside {SETUP, OUTLINE, SPAN, STEP}) ? col_d : '0;
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ox_q       <= '0;
         oy_q       <= '0;
         crit_q     <= '0;
         idx_q      <= '0;
         xpos_q     <= '0;
         vga_plot_q <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         vga_col_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         crit_q     <= crit_d;
         idx_q      <= idx_d;
         xpos_q     <= xpos_d;
         vga_plot_q <= vga_plot_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         vga_col_q  <= vga_col_d;
         done_q     <= done_d;
      end
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      r_q    <= r_d;
      col_q  <= col_d;
      fill_q <= fill_d;
   end

   assign done       = done_q;
   assign vga_plot   = vga_plot_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_col_q;
   assign state_dbg  = state_q;
endmodule

// File: tb/tb_circle_plot.sv
// Bench for circle_plot: an integer midpoint model builds the ordered, clipped pixel list
// and a negedge monitor scores every sink transfer against it.
module tb_circle_plot;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int RW = 8;
   localparam int CW = 3;
   localparam int IDLE_ENC = 0;

   logic          clk, rst, start, done, fill, vga_plot, vga_ready;
   logic [XW-1:0] centre_x, vga_x;
   logic [YW-1:0] centre_y, vga_y;
   logic [RW-1:0] radius;
   logic [CW-1:0] colour, vga_colour;
   logic [2:0]    state_dbg;

   logic [XW+YW-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int xfers = 0;
   int done_seen = 0;
   int exp_col = 0;
   int ready_mode = 0;
   int cyc;
   logic          hold_pend = 1'b0;
   logic [XW+YW-1:0] hold_xy;
   logic [CW-1:0] hold_col;

   circle_plot #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .XW(XW), .YW(YW), .RW(RW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour), .fill(fill),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .vga_ready(vga_ready), .state_dbg(state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void push_pt(input int x, input int y);
      if (x >= 0 && x < SCREEN_W && y >= 0 && y < SCREEN_H) exp_q.push_back({XW'(x), YW'(y)});
   endfunction

   // Reference: midpoint circle over the first octant, mirrored or spanned, then clipped.
   function automatic void build_expected(input int cx, input int cy, input int r, input int f);
      int ox = r;
      int oy = 0;
      int crit = 1 - r;
      exp_q.delete();
      do begin
         if (f == 0) begin
            push_pt(cx + ox, cy + oy); push_pt(cx + oy, cy + ox);
            push_pt(cx - oy, cy + ox); push_pt(cx - ox, cy + oy);
            push_pt(cx - ox, cy - oy); push_pt(cx - oy, cy - ox);
            push_pt(cx + oy, cy - ox); push_pt(cx + ox, cy - oy);
         end else begin
            for (int x = cx - ox; x <= cx + ox; x++) push_pt(x, cy + oy);
            for (int x = cx - ox; x <= cx + ox; x++) push_pt(x, cy - oy);
            for (int x = cx - oy; x <= cx + oy; x++) push_pt(x, cy + ox);
            for (int x = cx - oy; x <= cx + oy; x++) push_pt(x, cy - ox);
         end
         oy++;
         if (crit <= 0) crit += 2 * oy + 1;
         else begin
            ox--;
            crit += 2 * (oy - ox) + 1;
         end
      end while (oy <= ox);
   endfunction

   initial begin
      vga_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       vga_ready = 1'b1;
            1:       vga_ready = !vga_ready;
            default: vga_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      if (!vga_plot) begin
         check("zero_x_no_plot", int'(vga_x), 0);
         check("zero_y_no_plot", int'(vga_y), 0);
      end
      if (hold_pend) begin
         check("hold_plot", int'(vga_plot), 1);
         check("hold_xy", int'({vga_x, vga_y}), int'(hold_xy));
         check("hold_colour", int'(vga_colour), int'(hold_col));
      end
      hold_pend = vga_plot && !vga_ready && start && !rst;
      hold_xy   = {vga_x, vga_y};
      hold_col  = vga_colour;
      if (vga_plot && vga_ready) begin
         xfers++;
         check("on_screen", int'((int'(vga_x) < SCREEN_W) && (int'(vga_y) < SCREEN_H)), 1);
         check("pixel_colour", int'(vga_colour), exp_col);
         check("pixel_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("pixel_xy", int'({vga_x, vga_y}), int'(exp_q.pop_front()));
      end
      if (done) done_seen = 1;
   end

   task automatic launch(input int cx, input int cy, input int r, input int col, input int f);
      exp_col    = col;
      xfers      = 0;
      done_seen  = 0;
      centre_x   = XW'(cx);
      centre_y   = YW'(cy);
      radius     = RW'(r);
      colour     = CW'(col);
      fill       = 1'(f);
      start      = 1'b1;
   endtask

   task automatic draw(input int cx, input int cy, input int r, input int col, input int f,
                       input int mode, input string tag);
      int n;
      int c = 0;
      build_expected(cx, cy, r, f);
      n = exp_q.size();
      @(posedge clk); #1;
      ready_mode = mode;
      launch(cx, cy, r, col, f);
      @(posedge clk); #1;
      // Captured values must win over anything presented after the start edge.
      centre_x = XW'($urandom);
      centre_y = YW'($urandom);
      radius   = RW'($urandom);
      colour   = CW'($urandom);
      fill     = 1'($urandom_range(0, 1));
      while (!done && c < 30000) begin
         @(posedge clk); #1;
         c++;
      end
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_count"}, xfers, n);
      check({tag, "_left_over"}, exp_q.size(), 0);
      check({tag, "_done_plot"}, int'(vga_plot), 0);
      check({tag, "_done_colour"}, int'(vga_colour), 0);
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_held"}, int'(done), 1);
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, "_release_done"}, int'(done), 0);
      check({tag, "_release_state"}, int'(state_dbg), IDLE_ENC);
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      centre_x = '0; centre_y = '0; radius = '0; colour = '0; fill = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", int'(state_dbg), IDLE_ENC);
      check("rst_done", int'(done), 0);
      check("rst_plot", int'(vga_plot), 0);
      check("rst_x", int'(vga_x), 0);
      check("rst_y", int'(vga_y), 0);
      check("rst_colour", int'(vga_colour), 0);
      rst = 1'b0;

      draw(80, 60, 0, 5, 0, 0, "r0_outline");
      check("r0_outline_eight", xfers, 8);
      draw(80, 60, 1, 3, 0, 0, "r1_outline");
      check("r1_outline_sixteen", xfers, 16);
      draw(80, 60, 0, 2, 1, 0, "r0_fill");
      check("r0_fill_four", xfers, 4);
      draw(0, 0, 10, 7, 0, 0, "corner_clip");
      draw(80, 60, 2, 6, 1, 1, "r2_fill_toggle");
      draw(255, 127, 100, 1, 0, 2, "far_corner");
      draw(5, 5, 30, 4, 1, 2, "edge_fill");

      // Abort mid-draw, then restart the same circle in full.
      build_expected(80, 60, 40, 0);
      @(posedge clk); #1;
      ready_mode = 0;
      launch(80, 60, 40, 2, 0);
      repeat (60) @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("abort_state", int'(state_dbg), IDLE_ENC);
      check("abort_plot", int'(vga_plot), 0);
      check("abort_colour", int'(vga_colour), 0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_seen, 0);
      exp_q.delete();
      draw(80, 60, 40, 2, 0, 0, "restart");

      // Reset while spans are being emitted.
      build_expected(80, 60, 20, 1);
      @(posedge clk); #1;
      launch(80, 60, 20, 5, 1);
      cyc = 0;
      while (!vga_plot && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("span_reached", int'(vga_plot), 1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      check("span_rst_state", int'(state_dbg), IDLE_ENC);
      check("span_rst_done", int'(done), 0);
      check("span_rst_plot", int'(vga_plot), 0);
      check("span_rst_x", int'(vga_x), 0);
      check("span_rst_y", int'(vga_y), 0);
      check("span_rst_colour", int'(vga_colour), 0);
      rst = 1'b0;
      exp_q.delete();

      for (int i = 0; i < 4; i++) begin
         draw($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 20),
              $urandom_range(0, 7), $urandom_range(0, 1), 2, "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/circle_plot.md
CIRCLE_PLOT -- requirements
Module: circle_plot

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning the visible pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning the visible pixel rows.
REQ-003 SHALL have parameter XW, default 8, meaning the x coordinate width.
REQ-004 SHALL have parameter YW, default 7, meaning the y coordinate width.
REQ-005 SHALL have parameter RW, default 8, meaning the radius width.
REQ-006 SHALL have parameter CW, default 3, meaning the colour width.
REQ-007 SHALL provide port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL provide port rst, input, 1 bit, a synchronous active-high reset.
REQ-009 SHALL provide ports start (in, 1, level request) and done (out, 1, completion flag).
REQ-010 SHALL provide ports centre_x (in, XW), centre_y (in, YW), radius (in, RW), colour (in, CW) and fill (in, 1, where 0 means outline and 1 means filled disc).
REQ-011 SHALL provide ports vga_x (out, XW), vga_y (out, YW), vga_colour (out, CW), vga_plot (out, 1, pixel valid) and vga_ready (in, 1, sink accepts).

Function
REQ-012 SHALL use the states IDLE, SETUP, OUTLINE, SPAN, STEP and DONE.
REQ-013 SHALL, in IDLE with start=1, capture centre_x, centre_y, radius, colour and fill on that edge and go to SETUP; later input changes SHALL be ignored until the block returns to IDLE.
REQ-014 SHALL, in SETUP, load ox=radius, oy=0 and crit=1-radius, then go to OUTLINE when fill=0 or SPAN when fill=1, presenting the first candidate pixel on the cycle after SETUP.
REQ-015 SHALL do all coordinate arithmetic signed, at max(XW,YW,RW)+2 bits, with no wrap-around; crit SHALL be signed RW+2 bits.
REQ-016 SHALL, in OUTLINE, present the 8 octant points in fixed order: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-oy,cy+ox), (cx-ox,cy+oy), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+oy,cy-ox), (cx+ox,cy-oy).
REQ-017 SHALL, in SPAN, emit 4 horizontal spans per step, each left to right: row cy+oy over cx-ox..cx+ox, row cy-oy over the same range, row cy+ox over cx-oy..cx+oy, and row cy-ox over the same range.
REQ-018 SHALL permit duplicate pixels; no deduplication is performed.
REQ-019 SHALL, when the candidate lies inside 0<=x<SCREEN_W and 0<=y<SCREEN_H, drive vga_plot=1 with vga_x, vga_y and vga_colour stable, holding them until vga_ready=1; a pixel is transferred on the cycle where vga_plot and vga_ready are both high.
REQ-020 SHALL skip an off-screen candidate in exactly one cycle with vga_plot=0, independent of vga_ready.
REQ-021 SHALL drive vga_x and vga_y to 0 whenever vga_plot=0.
REQ-022 SHALL drive vga_colour to the captured colour while a draw is active and to 0 in IDLE and DONE.
REQ-023 SHALL, in STEP, update as follows: if crit<=0 then oy+=1 and crit+=2*oy_new+1; otherwise oy+=1, ox-=1 and crit+=2*(oy_new-ox_new)+1.
REQ-024 SHALL, after STEP, go to DONE when oy>ox and otherwise re-enter OUTLINE or SPAN; STEP takes one cycle with vga_plot=0.
REQ-025 SHALL hold done=1 only in DONE, stay in DONE while start=1, and go to IDLE on the cycle after start=0.
REQ-026 SHALL abort from any state other than IDLE or DONE when start=0: go to IDLE next cycle with vga_plot=0 on that cycle; a transfer pending on that cycle still completes if vga_ready=1.
REQ-027 SHALL, with radius=0, draw the centre once per emitted point: 8 plots in outline mode and 4 plots in fill mode.
REQ-028 SHALL handle centre or radius values that place part or all of the circle off-screen correctly through clipping alone, with no coordinate wrap.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0 and vga_colour=0, overriding any draw in progress.
REQ-030 SHALL reset ox, oy and crit to 0; the captured input registers need no reset.

Verification
REQ-031 SHALL be verified with centre (80,60), r=0, fill=0, ready=1 -> 8 plots of (80,60), then done=1.
REQ-032 SHALL be verified with centre (80,60), r=1, fill=0, ready=1 -> 16 plots; the first is (81,60) and the set is {(81,60),(79,60),(80,61),(80,59),(81,61),(79,61),(81,59),(79,59)}.
REQ-033 SHALL be verified with centre (0,0), r=10, fill=0 -> only x>=0, y>=0 plotted, and no plots with x>=SCREEN_W or y>=SCREEN_H.
REQ-034 SHALL be verified with centre (80,60), r=2, fill=1, and vga_ready toggling 1010 -> each pixel held until accepted, the plotted set equals the filled midpoint disc, and no pixel is lost.
REQ-035 SHALL be verified with start dropped mid-draw at r=40 -> IDLE within 1 cycle, done never asserted, and a restart draws the full circle.
REQ-036 SHALL be verified with rst=1 asserted during SPAN -> all outputs 0 on the next cycle and IDLE entered.
